// File: rtl/line_clear_if.sv
// Board-RAM port and control/status bundle between line_clear and its host.
// dbg_state mirrors the controller FSM state for checkers and debug.
interface line_clear_if #(
    parameter int COLOUR_W = 6
);
    logic                start;
    logic [COLOUR_W-1:0] ram_Q;
    logic [7:0]          ram_addr;
    logic [COLOUR_W-1:0] ram_data;
    logic                ram_wren;
    logic                busy;
    logic                done;
    logic [4:0]          lines;
    logic [2:0]          dbg_state;

    // Host / RAM side: drives start and read data, observes everything else.
    modport master (
        output start, ram_Q,
        input  ram_addr, ram_data, ram_wren, busy, done, lines, dbg_state
    );

    modport slave (
        input  start, ram_Q,
        output ram_addr, ram_data, ram_wren, busy, done, lines, dbg_state
    );
endinterface

// File: rtl/line_clear.sv
// Removes every full row from the board RAM, shifting the rows above it down,
// and reports how many rows were removed.
module line_clear #(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 24,
    parameter int COLOUR_W = 6
) (
    input  logic         clk,
    input  logic         resetn,
    line_clear_if.slave  bus
);
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    localparam logic [XW-1:0] X_LAST   = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(BOARD_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN_RD  = 3'd1,
        ST_SCAN_CHK = 3'd2,
        ST_SHIFT_RD = 3'd3,
        ST_SHIFT_WR = 3'd4,
        ST_CLR_TOP  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [YW-1:0] r_row, w_row_nxt;
    logic [YW-1:0] r_sr, w_sr_nxt;
    logic [XW-1:0] r_x, w_x_nxt;
    logic [4:0]    r_lines, w_lines_nxt;

    logic [YW-1:0]       w_addr_y;
    logic [XW-1:0]       w_addr_x;
    logic [COLOUR_W-1:0] w_wdata;
    logic                w_wren;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_sr    <= '0;
            r_x     <= '0;
            r_lines <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_sr    <= w_sr_nxt;
            r_x     <= w_x_nxt;
            r_lines <= w_lines_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_sr_nxt    = r_sr;
        w_x_nxt     = r_x;
        w_lines_nxt = r_lines;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_row_nxt   = ROW_LAST;
                    w_x_nxt     = '0;
                    w_lines_nxt = '0;
                    w_state_nxt = ST_SCAN_RD;
                end
            end
            ST_SCAN_RD: w_state_nxt = ST_SCAN_CHK;
            ST_SCAN_CHK: begin
                if (bus.ram_Q == '0) begin
                    w_x_nxt = '0;
                    if (r_row == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_row_nxt   = r_row - 1'b1;
                        w_state_nxt = ST_SCAN_RD;
                    end
                end else if (r_x != X_LAST) begin
                    w_x_nxt     = r_x + 1'b1;
                    w_state_nxt = ST_SCAN_RD;
                end else begin
                    // Row is full: count it and start moving everything above down.
                    if (r_lines != 5'd31) w_lines_nxt = r_lines + 1'b1;
                    w_sr_nxt    = r_row;
                    w_x_nxt     = '0;
                    w_state_nxt = (r_row != '0) ? ST_SHIFT_RD : ST_CLR_TOP;
                end
            end
            ST_SHIFT_RD: w_state_nxt = ST_SHIFT_WR;
            ST_SHIFT_WR: begin
                if (r_x != X_LAST) begin
                    w_x_nxt     = r_x + 1'b1;
                    w_state_nxt = ST_SHIFT_RD;
                end else begin
                    w_x_nxt = '0;
                    if (r_sr > YW'(1)) begin
                        w_sr_nxt    = r_sr - 1'b1;
                        w_state_nxt = ST_SHIFT_RD;
                    end else begin
                        w_state_nxt = ST_CLR_TOP;
                    end
                end
            end
            ST_CLR_TOP: begin
                // r_row is untouched here, so the same row is rescanned afterwards.
                if (r_x == X_LAST) begin
                    w_x_nxt     = '0;
                    w_state_nxt = ST_SCAN_RD;
                end else begin
                    w_x_nxt = r_x + 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_addr_y = '0;
        w_addr_x = '0;
        w_wdata  = '0;
        w_wren   = 1'b0;
        case (r_state)
            ST_SCAN_RD: begin
                w_addr_y = r_row;
                w_addr_x = r_x;
            end
            ST_SHIFT_RD: begin
                w_addr_y = r_sr - 1'b1;
                w_addr_x = r_x;
            end
            ST_SHIFT_WR: begin
                w_addr_y = r_sr;
                w_addr_x = r_x;
                w_wdata  = bus.ram_Q;
                w_wren   = 1'b1;
            end
            ST_CLR_TOP: begin
                w_addr_x = r_x;
                w_wren   = 1'b1;
            end
            default: begin
                w_addr_y = '0;
            end
        endcase
    end

    assign bus.ram_addr  = (8'(w_addr_y) * 8'(BOARD_W)) + 8'(w_addr_x);
    assign bus.ram_data  = w_wdata;
    assign bus.ram_wren  = w_wren;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.lines     = r_lines;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear: behavioural board RAM, hand-built board
// images, expected final boards, cycle counts and write-sequence checks.
module tb_line_clear;
    localparam int W = 10;
    localparam int H = 24;
    localparam logic [2:0] S_SHIFT_WR = 3'd4;

    logic clk;
    logic resetn;
    line_clear_if #(.COLOUR_W(6)) bus ();

    line_clear #(.BOARD_W(W), .BOARD_H(H), .COLOUR_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM model: one-cycle read latency, backdoor load from init_img
    logic [5:0]  mem [256];
    logic [5:0]  init_img [240];
    logic [5:0]  exp_img [240];
    logic        load_req;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 240; i++) mem[i] <= init_img[i];
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        bus.ram_Q <= mem[bus.ram_addr];
    end

    // Write and shift-state monitor
    logic [13:0] wr_log [1024];
    int          wr_total;
    int          shift_cyc;
    initial begin
        wr_total  = 0;
        shift_cyc = 0;
    end
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.ram_wren) begin
                wr_log[wr_total % 1024] <= {bus.ram_addr, bus.ram_data};
                wr_total <= wr_total + 1;
            end
            if (bus.dbg_state == 3'd3 || bus.dbg_state == 3'd4) shift_cyc <= shift_cyc + 1;
        end
    end

    // Scoreboard
    int total;
    int bad;
    logic [13:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_imgs();
        for (int i = 0; i < 240; i++) begin
            init_img[i] = '0;
            exp_img[i]  = '0;
        end
    endtask

    task automatic load_board();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    task automatic compare_ram(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < 240; i++) if (mem[i] !== exp_img[i]) diff++;
        check(tag, diff, 0);
    endtask

    // Pulse start, then count busy cycles until done; optional extra starts while busy
    task automatic run_op(input bit extra, output int busy_cyc, output int done_cyc);
        bit seen;
        busy_cyc = 0;
        done_cyc = 0;
        seen     = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int n = 1; n <= 3000 && !seen; n++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cyc = n;
                seen     = 1'b1;
            end else begin
                bus.start = (extra && (n % 37 == 5)) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        check("op_timeout", {31'd0, !seen}, 32'd0);
        @(negedge clk);
    endtask

    task automatic setup_t2();
        clear_imgs();
        for (int x = 0; x < W; x++) init_img[23*W + x] = 6'h01;
        init_img[22*W + 3] = 6'h15;
        exp_img[23*W + 3]  = 6'h15;
    endtask

    int bc, dc, wr0, sh0, fails;
    logic [13:0] e, a;

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        bus.start = 1'b0;
        load_req  = 1'b0;
        clear_imgs();
        #3;
        check("rst_busy",  {31'd0, bus.busy}, 0);
        check("rst_done",  {31'd0, bus.done}, 0);
        check("rst_wren",  {31'd0, bus.ram_wren}, 0);
        check("rst_lines", {27'd0, bus.lines}, 0);
        check("rst_addr",  {24'd0, bus.ram_addr}, 0);
        check("rst_data",  {26'd0, bus.ram_data}, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Empty board
        load_board();
        wr0 = wr_total;
        run_op(1'b0, bc, dc);
        check("empty_busy_cyc", bc, 49);
        check("empty_done_cyc", dc, 49);
        check("empty_lines", {27'd0, bus.lines}, 0);
        check("empty_writes", wr_total - wr0, 0);
        compare_ram("empty_ram");

        // Single full bottom row, one cell above drops into it
        setup_t2();
        load_board();
        run_op(1'b0, bc, dc);
        check("t2_lines", {27'd0, bus.lines}, 1);
        check("t2_busy_cyc", bc, 539);
        compare_ram("t2_ram");

        // Same board with start pulses during the operation
        load_board();
        run_op(1'b1, bc, dc);
        check("extra_start_cyc", bc, 539);
        check("extra_start_lines", {27'd0, bus.lines}, 1);
        compare_ram("extra_start_ram");

        // Two full rows separated by a partial row
        clear_imgs();
        for (int x = 0; x < W; x++) begin
            init_img[23*W + x] = 6'h3F;
            init_img[21*W + x] = 6'h3F;
        end
        init_img[22*W] = 6'h0A;
        exp_img[23*W]  = 6'h0A;
        load_board();
        run_op(1'b0, bc, dc);
        check("t3_lines", {27'd0, bus.lines}, 2);
        check("t3_busy_cyc", bc, 1011);
        compare_ram("t3_ram");

        // Only row 0 full: no shifting, just clearing the top row
        clear_imgs();
        for (int x = 0; x < W; x++) init_img[x] = 6'h2C;
        load_board();
        wr0 = wr_total;
        sh0 = shift_cyc;
        run_op(1'b0, bc, dc);
        check("t4_lines", {27'd0, bus.lines}, 1);
        check("t4_shift_cyc", shift_cyc - sh0, 0);
        check("t4_writes", wr_total - wr0, 10);
        check("t4_busy_cyc", bc, 79);
        compare_ram("t4_ram");
        for (int i = 0; i < W; i++) exp_q.push_back({8'(i), 6'h00});
        fails = 0;
        for (int i = 0; i < W; i++) begin
            e = exp_q.pop_front();
            a = wr_log[(wr0 + i) % 1024];
            if (a !== e) fails++;
        end
        check("t4_write_seq", fails, 0);

        // Abort during SHIFT_WR with an asynchronous reset
        setup_t2();
        load_board();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        fails = 1;
        for (int n = 0; n < 2000 && fails != 0; n++) begin
            if (bus.dbg_state == S_SHIFT_WR) fails = 0;
            else @(negedge clk);
        end
        check("abort_reach_shift_wr", fails, 0);
        check("abort_lines_pre", {27'd0, bus.lines}, 1);
        #2 resetn = 1'b0;
        #1;
        check("abort_busy",  {31'd0, bus.busy}, 0);
        check("abort_done",  {31'd0, bus.done}, 0);
        check("abort_wren",  {31'd0, bus.ram_wren}, 0);
        check("abort_lines", {27'd0, bus.lines}, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Fresh run after the abort
        setup_t2();
        load_board();
        run_op(1'b0, bc, dc);
        check("post_abort_lines", {27'd0, bus.lines}, 1);
        check("post_abort_cyc", bc, 539);
        compare_ram("post_abort_ram");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
- Upstream of the board renderer, which reads board RAM each frame and plots it to VGA.
- Runs once after a piece has been locked into board RAM.
- Scans the 10x24 board RAM from the bottom row up. Every completely filled row is removed: all rows above it shift down one and row 0 is filled with empty cells.
- Reports the number of rows removed so score logic can use it.
- Owns the RAM write port while busy. The renderer must not run while busy=1.

Parameters:
- BOARD_W, 10, columns per row (x = 0..BOARD_W-1).
- BOARD_H, 24, rows (y = 0..BOARD_H-1). Rows 0-3 are invisible but are scanned and shifted like any other row.
- COLOUR_W, 6, bits per cell. Value 0 means empty; any non-zero value is filled.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan. Sampled only in IDLE.
- ram_Q  input  COLOUR_W  board RAM read data. Valid the cycle after ram_addr is presented.
- ram_addr  output  8  board RAM address, computed as y*BOARD_W + x.
- ram_data  output  COLOUR_W  board RAM write data.
- ram_wren  output  1  board RAM write enable, active high.
- busy  output  1  high from the cycle after start is accepted until done is asserted (inclusive).
- done  output  1  one-cycle pulse when the operation finishes.
- lines  output  5  rows cleared by the last operation. Held until the next accepted start.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, ram_addr=0, ram_data=0, ram_wren=0, busy=0, done=0, lines=0, row/column/shift counters=0.
- Reset mid-operation aborts immediately. RAM contents are then undefined, and the caller must redo the lock.
- States: IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE.
- IDLE, start=1:
  - row=BOARD_H-1, x=0, lines=0.
  - Go to SCAN_RD.
  - start is ignored in every other state.
- SCAN_RD: ram_addr=(x,row). Go to SCAN_CHK.
- SCAN_CHK: examine ram_Q.
  - ram_Q==0 (row not full): if row==0 go to DONE; otherwise row-1, x=0, go to SCAN_RD.
  - ram_Q!=0 and x<BOARD_W-1: x+1, go to SCAN_RD.
  - ram_Q!=0 and x==BOARD_W-1 (row full): lines+1, shift row sr=row, x=0.
    - row>0: go to SHIFT_RD.
    - row==0: go to CLR_TOP.
- SHIFT_RD: ram_addr=(x,sr-1), ram_wren=0. Go to SHIFT_WR.
- SHIFT_WR: ram_addr=(x,sr), ram_data=ram_Q, ram_wren=1.
  - x<BOARD_W-1: x+1, go to SHIFT_RD.
  - Otherwise x=0; if sr>1 then sr-1 and go to SHIFT_RD, else go to CLR_TOP.
- CLR_TOP: one cell per cycle, ram_addr=(x,0), ram_data=0, ram_wren=1.
  - After x==BOARD_W-1: x=0, go to SCAN_RD on the same row, which is rescanned because new content has moved into it.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE. lines is stable from this cycle onward.
- ram_wren is high only in SHIFT_WR and CLR_TOP. ram_data=0 whenever ram_wren=0.
- Arithmetic:
  - Address product is computed at 8 bits; maximum value is 239.
  - lines saturates at 31. It is unreachable in practice, since at most 24 rows can clear.
- Cycle cost:
  - Empty-at-x=0 row: 2 cycles.
  - Full row scan: 2*BOARD_W cycles.
  - Shift of row r: 2*BOARD_W*r + BOARD_W cycles.
- Boundary cases:
  - Full row 0: no shift, CLR_TOP only.
  - Adjacent full rows: handled by the rescan.
  - Entirely full board: terminates with lines=24 and every cell empty.

Test Plan:
- Empty board, start pulse -> busy for cycles 1-49, done pulses in cycle 49, lines=0, ram_wren never asserted, RAM unchanged.
- Row 23 all 6'h01, cell (3,22)=6'h15, rest empty -> lines=1; (3,23)=6'h15; all other row-23 cells 0; rows 0-22 all 0.
- Rows 23 and 21 full (6'h3F), row 22 holds only (0,22)=6'h0A -> lines=2; (0,23)=6'h0A; every other cell 0.
- Only row 0 full -> lines=1; no SHIFT_RD/SHIFT_WR states visited; exactly 10 writes of 0 to addresses 0-9.
- Start pulses while busy, then resetn=0 during SHIFT_WR -> extra starts do not restart or extend the operation; on reset, busy/done/ram_wren/lines drop to 0 the same cycle without waiting for a clock edge; after resetn=1, a fresh start runs normally.
